bus_dma_master: RTL
===================

Name: bus_dma_master

Overview:
- Single-channel DMA engine that acts as a bus master on one master port of the two-master / two-slave shared bus.
- Copies SIZE 32-bit words from a source address range to a destination address range using the bus read/write protocol.
- Words move in chunks of up to BUF_DEPTH: a chunk is read into a local buffer, then written out.
- Typically instantiated on master port 1, with the CPU-side master on port 0.

Parameters:
- AW, 8, address width (matches bus address).
- DW, 32, data width (matches bus data).
- BUF_DEPTH, 4, chunk buffer depth in words; power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
- src_addr  input  AW  first source word address; latched on start.
- dst_addr  input  AW  first destination word address; latched on start.
- size  input  8  word count, 0..255; latched on start.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- m_req  output  1  bus request to arbiter.
- m_grant  input  1  bus grant from arbiter.
- m_wr  output  1  1 = write, 0 = read.
- m_address  output  AW  bus address.
- m_dout  output  DW  write data to bus.
- m_din  input  DW  read data from bus; valid the cycle after the read address is presented.

Behaviour:
- Reset (async, immediate, also mid-transfer): state=IDLE; busy, done, m_req, m_wr = 0; m_address, m_dout = 0; buffer contents don't-care; any transfer in progress is abandoned.
- States: IDLE, REQ, RD, CAP, WR, DONE.
- IDLE:
  - start with size=0 -> DONE; no bus request.
  - start with size>0 -> latch src, dst, remaining=size -> REQ.
- REQ: m_req=1; wait for m_grant=1, then -> RD with chunk_len=min(remaining, BUF_DEPTH).
- m_req stays 1 continuously from REQ through the last WR cycle. The arbiter holds a grant while its request is held.
- RD (chunk_len cycles):
  - Drive m_wr=0 and m_address=src+k, for k=0..chunk_len-1.
  - Capture m_din into buffer[k-1] for k≥1.
  - After the last address -> CAP.
- CAP (1 cycle): m_wr=0, m_address held at the last read address; capture m_din into buffer[chunk_len-1] -> WR.
- WR (chunk_len cycles):
  - Drive m_wr=1, m_address=dst+k, m_dout=buffer[k].
  - After the last word: src+=chunk_len, dst+=chunk_len, remaining-=chunk_len.
  - If remaining>0 -> RD (no re-request); else -> DONE.
- DONE (1 cycle): done=1, m_req=0, m_wr=0 -> IDLE.
- busy=1 in every state except IDLE.
- Outputs when not in RD/CAP/WR: m_wr=0, m_address=0, m_dout=0.
- Address arithmetic is modulo 2^AW; 0xFE+3 wraps to 0x01. Source and destination wrap independently.
- start while busy: ignored; no latching.
- Grant loss (m_grant=0 in RD/CAP/WR): abort the current chunk, return to REQ, and restart that chunk from its first word. src, dst and remaining are committed only at chunk completion. A write cycle that coincides with grant loss is treated as not performed.
- Cycle count, size=N≤BUF_DEPTH, grant arriving g cycles after REQ entry: busy high for 1+g+N+1+N+1 cycles.

Optional Feature:
- DMA_IRQ_EN defined:
  - Adds ports irq (output, 1) and irq_clr (input, 1).
  - irq is set on the DONE cycle, sticky, cleared by irq_clr. Reset value 0.
  - Set and clear in the same cycle -> irq stays 1.
- DMA_IRQ_EN undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Package dma_pkg:
  - state enum (IDLE, REQ, RD, CAP, WR, DONE).
  - Default AW/DW constants.
  - SIZE_W=8.
- Sub-module dma_chunk_buf:
  - BUF_DEPTH×DW register array.
  - Write port with index and enable; combinational read by index.
  - No reset on data.

Test Plan:
- Reset mid-RD of a 6-word transfer -> all outputs 0 the same cycle; memory unchanged past already-written words; a new start works afterwards.
- src=0x10, dst=0x90, size=3, slave memory preloaded with 0xA0..0xA2 -> dst words = 0xA0..0xA2; exactly 3 reads then 3 writes; done pulses once; busy lasts 1+g+3+1+3+1 cycles.
- size=10, BUF_DEPTH=4 -> chunks of 4, 4, 2; m_req never drops between chunks; all 10 words copied in order.
- src=0xFE, dst=0x20, size=4 -> reads 0xFE, 0xFF, 0x00, 0x01; writes 0x20..0x23.
- size=0 start -> done next cycle; m_req never asserts. A start pulse while busy -> no effect on the active transfer.
- Force m_grant low during the second WR cycle of a chunk -> FSM returns to REQ and re-reads/re-writes the whole chunk from its first word; final memory correct.
- DMA_IRQ_EN build: irq sets on DONE and holds; irq_clr clears it; simultaneous DONE and irq_clr -> irq=1.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and default widths for the bus DMA master.
// Contents: FSM state enum, default address/data widths, transfer size width.
package dma_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned SIZE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/dma_chunk_buf.sv
// Chunk buffer for the DMA master: DEPTH x DW registers, no reset on data.
// Ports: clk; we/widx/wdata write port; ridx index with combinational rdata_c.
module dma_chunk_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [DW-1:0]    wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [DW-1:0]    rdata_c
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata_c = mem[ridx];

endmodule

// File: rtl/bus_dma_master.sv
// Single-channel DMA bus master: copies `size` words from src to dst in
// chunks of up to BUF_DEPTH words (read chunk into buffer, then write it out).
// Ports: clk, reset_n (async, active low); start/src_addr/dst_addr/size launch;
//   busy, done status; m_req/m_grant/m_wr/m_address/m_dout/m_din bus master port.
// Optional: define DMA_IRQ_EN to add the sticky irq output and irq_clr input.
// All outputs are registered from next-state values so they line up with the
// state they belong to.
module bus_dma_master
  import dma_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AW-1:0]     src_addr,
  input  logic [AW-1:0]     dst_addr,
  input  logic [SIZE_W-1:0] size,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [AW-1:0]     m_address,
  output logic [DW-1:0]     m_dout,
  input  logic [DW-1:0]     m_din
`ifdef DMA_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam int unsigned IDX_W = $clog2(BUF_DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [LEN_W-1:0]  len, len_nx;
  logic [AW-1:0]     src, src_nx, dst, dst_nx;
  logic [SIZE_W-1:0] rem, rem_nx, rem_left;
  logic              last;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_widx;
  logic [DW-1:0]     buf_rdata_c;
  logic              busy_nx, done_nx, m_req_nx, m_wr_nx;
  logic [AW-1:0]     m_address_nx;
  logic [DW-1:0]     m_dout_nx;

  function automatic logic [LEN_W-1:0] chunk_len(input logic [SIZE_W-1:0] r);
    return (r > SIZE_W'(BUF_DEPTH)) ? LEN_W'(BUF_DEPTH) : LEN_W'(r);
  endfunction

  dma_chunk_buf #(.DEPTH(BUF_DEPTH), .DW(DW)) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .widx    (buf_widx),
    .wdata   (m_din),
    .ridx    (idx_nx),
    .rdata_c (buf_rdata_c)
  );

  // Next state, chunk bookkeeping and buffer capture.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    len_nx   = len;
    src_nx   = src;
    dst_nx   = dst;
    rem_nx   = rem;
    buf_we   = 1'b0;
    buf_widx = idx - IDX_W'(1);
    rem_left = rem - SIZE_W'(len);
    last     = (LEN_W'(idx) == len - LEN_W'(1));
    case (state)
      IDLE: begin
        if (start) begin
          if (size == '0) begin
            state_nx = DONE;
          end else begin
            src_nx   = src_addr;
            dst_nx   = dst_addr;
            rem_nx   = size;
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (m_grant) begin
          len_nx   = chunk_len(rem);
          idx_nx   = '0;
          state_nx = RD;
        end
      end
      RD: begin
        if (!m_grant) begin
          state_nx = REQ;
        end else begin
          // m_din now carries the word addressed in the previous cycle
          buf_we = (idx != '0);
          if (last) state_nx = CAP;
          else      idx_nx   = idx + IDX_W'(1);
        end
      end
      CAP: begin
        if (!m_grant) begin
          state_nx = REQ;
        end else begin
          buf_we   = 1'b1;
          buf_widx = IDX_W'(len - LEN_W'(1));
          idx_nx   = '0;
          state_nx = WR;
        end
      end
      WR: begin
        if (!m_grant) begin
          state_nx = REQ;
        end else if (last) begin
          // Chunk complete: only now commit the transfer progress
          src_nx = src + AW'(len);
          dst_nx = dst + AW'(len);
          rem_nx = rem_left;
          idx_nx = '0;
          if (rem_left != '0) begin
            len_nx   = chunk_len(rem_left);
            state_nx = RD;
          end else begin
            state_nx = DONE;
          end
        end else begin
          idx_nx = idx + IDX_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output values for the upcoming state.
  always_comb begin
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == DONE);
    m_req_nx     = (state_nx inside {REQ, RD, CAP, WR});
    m_wr_nx      = (state_nx == WR);
    m_address_nx = '0;
    m_dout_nx    = '0;
    case (state_nx)
      RD, CAP: m_address_nx = src_nx + AW'(idx_nx);
      WR: begin
        m_address_nx = dst_nx + AW'(idx_nx);
        // A one-word chunk enters WR on the same edge its word is captured
        m_dout_nx = (buf_we && (buf_widx == idx_nx)) ? m_din : buf_rdata_c;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      len       <= '0;
      src       <= '0;
      dst       <= '0;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_address <= '0;
      m_dout    <= '0;
    end else begin
      idx       <= idx_nx;
      len       <= len_nx;
      src       <= src_nx;
      dst       <= dst_nx;
      rem       <= rem_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      m_req     <= m_req_nx;
      m_wr      <= m_wr_nx;
      m_address <= m_address_nx;
      m_dout    <= m_dout_nx;
    end
  end

`ifdef DMA_IRQ_EN
  // Sticky completion interrupt; setting wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           irq <= 1'b0;
    else if (state == DONE) irq <= 1'b1;
    else if (irq_clr)       irq <= 1'b0;
  end
`endif

endmodule
